// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot loader: FSM encodings, error codes,
// stream framing constants and a length-validity helper.
package mips_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_SUM    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_SUM  = 2'b10
  } err_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // A word count is loadable when it is non-zero and fits the memory.
  function automatic logic len_ok(input logic [15:0] n, input int addr_w);
    return (n != 16'd0) && (32'(n) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
// slave = loader side, master = stream source / memory side.
interface mips_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, imem_wr_en, imem_addr, imem_wdata
  );

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, imem_wr_en, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_boot_loader_word_assembler.sv
// Big-endian word assembler: shifts stream bytes into a 32-bit register and
// raises a one-cycle word_done on the cycle after the 4th byte, when word
// already holds the completed value.
module loader_word_assembler
  import mips_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  // Shift bytes in MSB first; index wraps every WORD_BYTES transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word      <= '0;
      byte_idx  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= shift_en && (byte_idx == LAST_IDX);
      if (clear) begin
        byte_idx <= '0;
      end else if (shift_en) begin
        word     <= {word[23:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: receives LEN / DATA / SUM byte stream, writes words into the
// MIPS instruction memory and releases the core only after the checksum
// matches.
module mips_boot_loader
  import mips_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  mips_boot_loader_if.slave        bus,
  input  logic                     load_req,
  output logic                     core_rst,
  output logic                     done,
  output logic [1:0]               err_code
);

  state_t            state;
  logic              ready_q;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        csum;

  logic              xfer;
  logic [15:0]       len_n;
  logic              asm_clear;
  logic              asm_shift;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_word;
  logic              word_done;
  logic              last_byte;
  logic              last_word;

  assign xfer      = bus.byte_valid && ready_q;
  assign len_n     = {len_hi, bus.byte_data};
  assign asm_clear = (state == ST_LEN_LO) && xfer;
  assign asm_shift = (state == ST_DATA) && xfer;
  assign last_byte = asm_shift && (byte_idx == 2'(WORD_BYTES - 1));
  // Compared at 32 bits so N = 2^ADDR_W needs no extra index bit.
  assign last_word = (32'(word_idx) == (32'(len) - 32'd1));

  assign bus.byte_ready = ready_q;
  assign bus.imem_wr_en = word_done;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = asm_word;

  loader_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .shift_en (asm_shift),
    .byte_in  (bus.byte_data),
    .byte_idx (byte_idx),
    .word     (asm_word),
    .word_done(word_done)
  );

  // Load sequencer: framing, word counter, running XOR and core hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_LEN_HI;
      ready_q  <= 1'b0;
      len_hi   <= '0;
      len      <= '0;
      word_idx <= '0;
      addr_q   <= '0;
      csum     <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_LEN_HI: begin
          ready_q <= 1'b1;
          if (xfer) begin
            len_hi <= bus.byte_data;
            csum   <= csum ^ bus.byte_data;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            csum <= csum ^ bus.byte_data;
            if (len_ok(len_n, ADDR_W)) begin
              len      <= len_n;
              word_idx <= '0;
              state    <= ST_DATA;
            end else begin
              // Rest of the stream is left unconsumed.
              ready_q  <= 1'b0;
              err_code <= ERR_LEN;
              state    <= ST_ERROR;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.byte_data;
          end
          if (last_byte) begin
            addr_q <= word_idx;
            // Hold the index on the final word so it never wraps.
            if (last_word) begin
              state <= ST_SUM;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        ST_SUM: begin
          if (xfer) begin
            ready_q <= 1'b0;
            if (bus.byte_data == csum) begin
              done     <= 1'b1;
              core_rst <= 1'b0;
              state    <= ST_DONE;
            end else begin
              err_code <= ERR_SUM;
              state    <= ST_ERROR;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (load_req) begin
            ready_q  <= 1'b1;
            csum     <= '0;
            err_code <= ERR_NONE;
            core_rst <= 1'b1;
            done     <= 1'b0;
            state    <= ST_LEN_HI;
          end
        end
        default: begin
          ready_q  <= 1'b0;
          core_rst <= 1'b1;
          done     <= 1'b0;
          state    <= ST_LEN_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader. Expected memory writes are queued as
// bytes are sent; a negedge monitor pops and compares every write strobe.
module tb_mips_boot_loader;
  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_req = 1'b0;
  logic       core_rst;
  logic       done;
  logic [1:0] err_code;

  mips_boot_loader_if #(.ADDR_W(ADDR_W)) bif ();

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .load_req(load_req),
    .core_rst(core_rst),
    .done    (done),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  logic [31:0] img [0:CAP-1];
  logic [7:0]  csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bif.imem_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %h, expected no write",
                 bif.imem_addr, bif.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bif.imem_addr !== e.addr || bif.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0h data %h expected addr %0h data %h",
                   bif.imem_addr, bif.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Send one byte; returns at posedge+1 after it transfers.
  task automatic send_byte(input logic [7:0] b, input bit gapped);
    bit ok;
    int n;
    ok = 1'b0;
    if (gapped) begin
      bif.byte_valid = 1'b0;
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    bif.byte_data  = b;
    bif.byte_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bif.byte_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bif.byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got byte_ready 0 expected 1 for byte %h", b);
    end
  endtask

  task automatic send_len(input logic [15:0] n, input bit gapped);
    csum = 8'h00;
    send_byte(n[15:8], gapped);
    csum = csum ^ n[15:8];
    send_byte(n[7:0], gapped);
    csum = csum ^ n[7:0];
  endtask

  task automatic send_words(input int first, input int count, input bit gapped);
    logic [31:0] w;
    for (int i = first; i < first + count; i++) begin
      w = img[i];
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8], gapped);
        csum = csum ^ w[j*8 +: 8];
      end
      check("wr_en_after_4th_byte", bif.imem_wr_en, 1);
    end
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, bif.byte_ready, 0);
    check({tag, "_wr_en"},      bif.imem_wr_en, 0);
    check({tag, "_addr"},       bif.imem_addr, 0);
    check({tag, "_wdata"},      bif.imem_wdata, 0);
    check({tag, "_core_rst"},   core_rst, 1);
    check({tag, "_done"},       done, 0);
    check({tag, "_err"},        err_code, 0);
  endtask

  task automatic set_nominal();
    img[0] = 32'h2008_0005;
    img[1] = 32'hAC08_0000;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"},       done, 1);
    check({tag, "_core_rst"},   core_rst, 0);
    check({tag, "_byte_ready"}, bif.byte_ready, 0);
    check({tag, "_err"},        err_code, 0);
  endtask

  initial begin
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;

    // Reset values while rst is held low.
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bif.byte_ready, 1);
    check("core_rst_loading", core_rst, 1);

    // Nominal load; SUM = 00^02^20^08^00^05^AC^08^00^00 = 8B.
    set_nominal();
    send_len(16'd2, 1'b0);
    send_words(0, 2, 1'b0);
    send_byte(8'h8B, 1'b0);
    check_done("nominal");

    // Valid held while not ready: nothing happens.
    bif.byte_data  = 8'h55;
    bif.byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    check_done("idle_valid");

    // Reload; load_req during DATA is ignored.
    pulse_load_req();
    check("reload_core_rst", core_rst, 1);
    check("reload_done", done, 0);
    check("reload_ready", bif.byte_ready, 1);
    img[0] = 32'h8C09_0000;
    img[1] = 32'h0109_5020;
    img[2] = 32'h0000_0000;
    send_len(16'd3, 1'b0);
    send_words(0, 1, 1'b0);
    pulse_load_req();
    check("load_req_in_data_ready", bif.byte_ready, 1);
    send_words(1, 2, 1'b0);
    send_byte(csum, 1'b0);
    check_done("reload");

    // Checksum mismatch.
    pulse_load_req();
    set_nominal();
    send_len(16'd2, 1'b0);
    send_words(0, 2, 1'b0);
    send_byte(8'h8B ^ 8'h01, 1'b0);
    check("sum_err_code", err_code, 2);
    check("sum_err_done", done, 0);
    check("sum_err_core_rst", core_rst, 1);
    check("sum_err_ready", bif.byte_ready, 0);

    // Bad length: zero, then capacity + 1.
    pulse_load_req();
    check("err_cleared", err_code, 0);
    send_len(16'd0, 1'b0);
    check("len0_err", err_code, 1);
    check("len0_ready", bif.byte_ready, 0);
    check("len0_core_rst", core_rst, 1);
    pulse_load_req();
    send_len(16'(CAP + 1), 1'b0);
    check("len_big_err", err_code, 1);
    check("len_big_ready", bif.byte_ready, 0);

    // Gapped stream gives the same result as the nominal load.
    pulse_load_req();
    set_nominal();
    send_len(16'd2, 1'b1);
    send_words(0, 2, 1'b1);
    send_byte(8'h8B, 1'b1);
    check_done("gapped");

    // Reset in the middle of DATA, then a clean load.
    pulse_load_req();
    send_len(16'd2, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_len(16'd2, 1'b0);
    send_words(0, 2, 1'b0);
    send_byte(8'h8B, 1'b0);
    check_done("after_reset");

    // Full-capacity image: last write lands at the top address.
    pulse_load_req();
    for (int i = 0; i < CAP; i++) img[i] = 32'h1000_0000 + i * 32'h0001_0003;
    send_len(16'(CAP), 1'b0);
    send_words(0, CAP, 1'b0);
    send_byte(csum, 1'b0);
    check_done("full_cap");
    check("full_cap_last_addr", bif.imem_addr, CAP - 1);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
